// File: rtl/pellet_eater_pkg.sv
// pellet_eater_pkg: map geometry, score constants, pellet codes and FSM states
package pellet_eater_pkg;

  localparam int MAP_W        = 32;
  localparam int MAP_H        = 36;
  localparam int TILE_PX      = 8;
  localparam int SCORE_DIGITS = 5;
  localparam int PELLET_PTS   = 10;
  localparam int POWER_PTS    = 50;

  localparam int MAP_TILES  = MAP_W * MAP_H;
  localparam int ADDR_W     = $clog2(MAP_TILES);
  localparam int POS_W      = 9;
  localparam int TILE_SHIFT = $clog2(TILE_PX);
  localparam int COORD_W    = POS_W - TILE_SHIFT;
  localparam int SCORE_W    = 4 * SCORE_DIGITS;
  localparam int COUNT_W    = 11;

  localparam logic [COORD_W-1:0] MAP_W_TILES = COORD_W'(MAP_W);
  localparam logic [COORD_W-1:0] MAP_H_TILES = COORD_W'(MAP_H);
  localparam logic [ADDR_W-1:0]  ROW_STRIDE  = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(MAP_TILES - 1);

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SMALL = 2'd1,
    POWER = 2'd2,
    RSVD  = 2'd3
  } pellet_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CHECK,
    EAT,
    CLEAR
  } eat_state_t;

  // Only small and power pellets are edible and counted; reserved behaves as empty
  function automatic logic isPellet(input logic [1:0] code);
    return (code == SMALL) || (code == POWER);
  endfunction

  // Converts a small point value into packed BCD, digit 0 in the low nibble
  function automatic logic [SCORE_W-1:0] toBcd(input int unsigned value);
    logic [SCORE_W-1:0] result;
    int unsigned rest;
    result = '0;
    rest   = value;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      result[4*d +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

  localparam logic [SCORE_W-1:0] PELLET_BCD = toBcd(PELLET_PTS);
  localparam logic [SCORE_W-1:0] POWER_BCD  = toBcd(POWER_PTS);

endpackage

// File: rtl/pellet_eater_bcd_adder.sv
// bcd_adder: single-cycle packed-BCD adder that clamps to all nines instead of wrapping
module bcd_adder #(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  output logic [4*DIGITS-1:0] sum_o
);

  logic [4*DIGITS-1:0] rawSum;
  logic                carry;
  logic [4:0]          digitSum;

  // Ripple a decimal carry through the digits; a carry out of the top digit saturates
  always_comb begin
    rawSum   = '0;
    carry    = 1'b0;
    digitSum = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digitSum = {1'b0, a_i[4*d +: 4]} + {1'b0, b_i[4*d +: 4]} + {4'b0000, carry};
      if (digitSum > 5'd9) begin
        rawSum[4*d +: 4] = 4'(digitSum - 5'd10);
        carry            = 1'b1;
      end else begin
        rawSum[4*d +: 4] = digitSum[3:0];
        carry            = 1'b0;
      end
    end
    sum_o = carry ? {DIGITS{4'h9}} : rawSum;
  end

endmodule

// File: rtl/pellet_eater.sv
// pellet_eater: owns the pellet layer, loads it from the layout ROM and scores eaten pellets
module pellet_eater
  import pellet_eater_pkg::*;
(
  input  logic                vga_pix_clk,
  input  logic                rst_n,
  input  logic                frame_stb,
  input  logic [POS_W-1:0]    x_pac,
  input  logic [POS_W-1:0]    y_pac,
  output logic [ADDR_W-1:0]   init_addr,
  input  logic [1:0]          init_data,
  input  logic [ADDR_W-1:0]   draw_addr,
  output logic [1:0]          draw_pellet,
  output logic [SCORE_W-1:0]  score_bcd,
  output logic [COUNT_W-1:0]  pellets_left,
  output logic                power_pulse,
  output logic                init_done,
  output logic                level_clear
);

  eat_state_t          state_q;
  logic [ADDR_W-1:0]   initAddr_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic                wrValid_q;
  logic [POS_W-1:0]    xPac_q;
  logic [POS_W-1:0]    yPac_q;
  logic [ADDR_W-1:0]   eatAddr_q;
  logic [SCORE_W-1:0]  score_q;
  logic [COUNT_W-1:0]  pelletsLeft_q;
  logic                powerPulse_q;
  logic                initDone_q;
  logic                levelClear_q;
  logic [1:0]          portARead_q;
  logic [1:0]          drawPellet_q;

  logic [1:0]          pelletRam [MAP_TILES];

  logic [SCORE_W-1:0]  score_d;
  logic [SCORE_W-1:0]  addend;
  logic [COUNT_W-1:0]  initCount_d;
  logic [COORD_W-1:0]  tileX;
  logic [COORD_W-1:0]  tileY;
  logic                aligned;
  logic                onMap;
  logic [ADDR_W-1:0]   tileIdx;
  logic                ramWe;
  logic [ADDR_W-1:0]   ramAddr;
  logic [1:0]          ramWdata;

  assign tileX   = xPac_q[POS_W-1:TILE_SHIFT];
  assign tileY   = yPac_q[POS_W-1:TILE_SHIFT];
  assign aligned = (xPac_q[TILE_SHIFT-1:0] == '0) && (yPac_q[TILE_SHIFT-1:0] == '0);
  assign onMap   = (tileX < MAP_W_TILES) && (tileY < MAP_H_TILES);
  assign tileIdx = ADDR_W'(tileY) * ROW_STRIDE + ADDR_W'(tileX);

  assign initCount_d = pelletsLeft_q + COUNT_W'(isPellet(init_data));
  assign addend      = (portARead_q == POWER) ? POWER_BCD : PELLET_BCD;

  bcd_adder #(
    .DIGITS(SCORE_DIGITS)
  ) scoreAdder (
    .a_i  (score_q),
    .b_i  (addend),
    .sum_o(score_d)
  );

  // Port A steering: layout writes during the sweep, clearing writes in EAT, lookups otherwise
  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = tileIdx;
    ramWdata = NONE;
    case (state_q)
      INIT: begin
        if (wrValid_q) begin
          ramWe    = 1'b1;
          ramAddr  = wrAddr_q;
          ramWdata = init_data;
        end
      end
      EAT: begin
        if (isPellet(portARead_q)) begin
          ramWe   = 1'b1;
          ramAddr = eatAddr_q;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      ramWe = 1'b0;
    end
  end

  // Pellet RAM port A: read-first synchronous access shared by the sweep and the eater
  always_ff @(posedge vga_pix_clk) begin
    if (ramWe) begin
      pelletRam[ramAddr] <= ramWdata;
    end
    portARead_q <= pelletRam[ramAddr];
  end

  // Pellet RAM port B: read-only view for the drawing logic
  always_ff @(posedge vga_pix_clk) begin
    drawPellet_q <= pelletRam[draw_addr];
  end

  // Main controller: layout sweep, frame capture, eligibility check and eat bookkeeping
  always_ff @(posedge vga_pix_clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      initAddr_q    <= '0;
      wrAddr_q      <= '0;
      wrValid_q     <= 1'b0;
      xPac_q        <= '0;
      yPac_q        <= '0;
      eatAddr_q     <= '0;
      score_q       <= '0;
      pelletsLeft_q <= '0;
      powerPulse_q  <= 1'b0;
      initDone_q    <= 1'b0;
      levelClear_q  <= 1'b0;
    end else begin
      powerPulse_q <= 1'b0;
      case (state_q)
        INIT: begin
          wrAddr_q  <= initAddr_q;
          wrValid_q <= 1'b1;
          if (initAddr_q != LAST_ADDR) begin
            initAddr_q <= initAddr_q + ADDR_W'(1);
          end
          if (wrValid_q) begin
            pelletsLeft_q <= initCount_d;
            if (wrAddr_q == LAST_ADDR) begin
              initDone_q <= 1'b1;
              if (initCount_d == '0) begin
                state_q      <= CLEAR;
                levelClear_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        IDLE: begin
          if (frame_stb) begin
            xPac_q  <= x_pac;
            yPac_q  <= y_pac;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (aligned && onMap) begin
            eatAddr_q <= tileIdx;
            state_q   <= EAT;
          end else begin
            state_q <= IDLE;
          end
        end
        EAT: begin
          state_q <= IDLE;
          if (isPellet(portARead_q) && (pelletsLeft_q != '0)) begin
            score_q       <= score_d;
            pelletsLeft_q <= pelletsLeft_q - COUNT_W'(1);
            powerPulse_q  <= (portARead_q == POWER);
            if (pelletsLeft_q == COUNT_W'(1)) begin
              state_q      <= CLEAR;
              levelClear_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state_q <= CLEAR;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign init_addr    = initAddr_q;
  assign draw_pellet  = drawPellet_q;
  assign score_bcd    = score_q;
  assign pellets_left = pelletsLeft_q;
  assign power_pulse  = powerPulse_q;
  assign init_done    = initDone_q;
  assign level_clear  = levelClear_q;

endmodule

// File: doc/pellet_eater.md
Name: pellet_eater

Overview:
- Sits directly downstream of the pacman movement stage and consumes its x_pac/y_pac tile-pixel position once per frame.
- Owns the pellet layer: a per-tile pellet-state RAM loaded from a layout ROM after reset.
- When Pac-Man sits exactly on a tile holding a pellet, it clears that pellet, adds points to a BCD score, and counts down the remaining pellets.
- Exposes a 1-cycle-latency read port so the drawing logic can render pellets.

Parameters:
- MAP_W, 32, map width in tiles
- MAP_H, 36, map height in tiles
- TILE_PX, 8, tile size in pixels (power of two)
- SCORE_DIGITS, 5, number of BCD score digits
- PELLET_PTS, 10, points for a small pellet
- POWER_PTS, 50, points for a power pellet

Ports:
- vga_pix_clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- frame_stb  in  1  one-cycle strobe per frame
- x_pac  in  9  Pac-Man x position in pixels
- y_pac  in  9  Pac-Man y position in pixels
- init_addr  out  $clog2(MAP_W*MAP_H)  layout ROM address
- init_data  in  2  layout ROM data, valid 1 cycle after init_addr
- draw_addr  in  $clog2(MAP_W*MAP_H)  drawing-logic tile index
- draw_pellet  out  2  pellet state at draw_addr, 1 cycle later
- score_bcd  out  4*SCORE_DIGITS  score in BCD, digit 0 = LSD
- pellets_left  out  11  pellets remaining (small + power)
- power_pulse  out  1  one-cycle pulse when a power pellet is eaten
- init_done  out  1  high once the layout load completes
- level_clear  out  1  high when pellets_left reaches 0 after init

Behaviour:
- Pellet codes: 0 none, 1 small, 2 power, 3 reserved (treated as none, not counted).
- Reset (rst_n=0 at a clock edge):
  - FSM goes to INIT.
  - init_addr=0, score=0, pellets_left=0.
  - power_pulse=0, init_done=0, level_clear=0.
  - Reset mid-sweep or mid-eat aborts immediately; the RAM is fully rewritten by the next sweep.
- INIT:
  - init_addr steps 0..MAP_W*MAP_H-1, one address per cycle.
  - Data returned one cycle later is written to RAM[addr-1].
  - pellets_left increments for codes 1 and 2.
  - Sweep takes MAP_W*MAP_H+1 cycles, after which init_done=1 and the FSM moves to IDLE.
  - frame_stb is ignored during INIT.
- IDLE:
  - On frame_stb, capture x_pac/y_pac as presented on that same cycle, then go to CHECK.
- CHECK:
  - Eligible only if x[2:0]==0, y[2:0]==0, x/TILE_PX < MAP_W and y/TILE_PX < MAP_H. If not eligible, return to IDLE.
  - Tile index = (y/TILE_PX)*MAP_W + x/TILE_PX; issue the RAM read, then go to EAT.
- EAT (data valid this cycle):
  - Code 1: write 0, add PELLET_PTS, pellets_left-1.
  - Code 2: write 0, add POWER_PTS, pellets_left-1, power_pulse=1 for this cycle only.
  - Otherwise: no change.
  - Then go to IDLE, or to CLEAR if pellets_left becomes 0.
- CLEAR:
  - level_clear=1; frame_stb is ignored; stay until reset.
  - A layout with 0 pellets goes INIT -> CLEAR directly.
- Frame-to-score latency: eat updates score_bcd and pellets_left 3 cycles after the frame_stb edge.
- frame_stb arriving in CHECK/EAT is dropped; frames are far longer than 3 cycles.
- Score arithmetic:
  - BCD add, single cycle, per-digit decimal carry.
  - Saturates at all 9s (99999 for 5 digits); never wraps.
- RAM:
  - True dual port. Port A: init/eat writes and eat reads. Port B: draw read only.
  - draw_pellet reflects a same-cycle port-A write no earlier than the following cycle (read-first).
- pellets_left never underflows; a 0 count cannot coexist with a pellet in RAM by construction.

Decomposition:
- Shared params package:
  - pellet code enum pellet_t (NONE, SMALL, POWER, RSVD).
  - MAP_W/MAP_H/TILE_PX constants.
  - Point values.
  - FSM enum eat_state_t (INIT, IDLE, CHECK, EAT, CLEAR).
- Sub-module bcd_adder (SCORE_DIGITS-wide, saturating, combinational) instantiated once.
- Pellet RAM inferred inline.

Test Plan:
- Layout with pellets at tiles 33 (small) and 34 (power), all else 0:
  - init_done rises 1153 cycles after rst_n release; pellets_left=2; draw_addr=33 -> draw_pellet=1 next cycle.
- x_pac=8, y_pac=8, one frame_stb:
  - 3 cycles later score_bcd=0x00010, pellets_left=1, draw_pellet at tile 33 reads 0; a second frame at the same position leaves score unchanged.
- x_pac=16, y_pac=8, frame_stb:
  - power_pulse high exactly one cycle; score=0x00060; pellets_left=0; level_clear=1; further frame_stb has no effect.
- x_pac=9, y_pac=8 (unaligned) and x_pac=256 (off-map):
  - no RAM write, score and pellets_left unchanged.
- Score preset near max (99990 via forced layout of small pellets):
  - eating a small pellet gives 99999 (saturates, no wrap).
- rst_n low during INIT sweep at address 500 and during EAT:
  - outputs return to reset values next cycle; full re-sweep restores the original layout and pellet count.
